// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-lite transfer and response types
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      OKAY  = 2'b00,
      ERROR = 2'b01
   } hresp_t;

   localparam int unsigned WAIT_CNT_W = 3;

   // NONSEQ and SEQ carry a real transfer; IDLE and BUSY are no-ops
   function automatic logic is_active(input htrans_t t);
      return (t == NONSEQ) || (t == SEQ);
   endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// rtl/ahb_sram_array.sv - word SRAM with sync write, registered read and write forwarding
module ahb_sram_array #(
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Write port; contents survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read; a same-edge write to the same word is forwarded so the reader sees new data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
      end
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-lite SRAM responder with configurable wait states
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int          DEPTH       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        HSel,
   input  logic [31:0] HAddr,
   input  logic [1:0]  HTrans,
   input  logic        HWrite,
   input  logic        ReadyIn,
   input  logic [31:0] HWData,
   output logic [31:0] HRData,
   output logic        HReadyOut,
   output logic [1:0]  HResp
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);
   localparam logic [WAIT_CNT_W-1:0] WS_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LAST,
      S_ERR1,
      S_ERR2
   } slave_state_t;

   localparam slave_state_t OK_NEXT = (WAIT_STATES > 0) ? S_WAIT : S_LAST;

   slave_state_t            state;
   slave_state_t            state_nxt;
   logic [WAIT_CNT_W-1:0]   wait_cnt;
   logic [AW-1:0]           addr_q;
   logic                    write_q;

   logic [31:0]             offset;
   logic [AW-1:0]           addr_idx;
   logic                    dec_err;
   logic                    can_accept;
   logic                    accept;
   logic                    acc_last;
   logic                    wait_last;
   logic                    mem_we;
   logic                    mem_re;
   logic [AW-1:0]           mem_raddr;
   hresp_t                  resp;

   // Unsigned offset wraps for addresses below the base, so one compare covers both window edges
   assign offset   = HAddr - BASE_ADDR;
   assign addr_idx = offset[AW+1:2];
   assign dec_err  = (HAddr[1:0] != 2'b00) || (offset >= SPAN);

   // A new address phase is only taken when the previous data phase is finishing or absent
   assign can_accept = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
   assign accept     = can_accept && HSel && ReadyIn && is_active(htrans_t'(HTrans));

   // Edges that enter LAST: straight from an accept (no wait states) or from the final wait cycle
   assign acc_last  = accept && !dec_err && (WAIT_STATES == 0);
   assign wait_last = (state == S_WAIT) && (wait_cnt == '0);

   assign mem_we    = (state == S_LAST) && write_q;
   assign mem_re    = (acc_last && !HWrite) || (wait_last && !write_q);
   assign mem_raddr = acc_last ? addr_idx : addr_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; IDLE, LAST and ERR2 share the accept rules
   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:  if (wait_cnt == '0) state_nxt = S_LAST;
         S_ERR1:  state_nxt = S_ERR2;
         default: begin
            if (accept) begin
               state_nxt = dec_err ? S_ERR1 : OK_NEXT;
            end else begin
               state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // Per-state bus response
   always_comb begin
      HReadyOut = 1'b1;
      resp      = OKAY;
      case (state)
         S_WAIT:  HReadyOut = 1'b0;
         S_ERR1: begin
            HReadyOut = 1'b0;
            resp      = ERROR;
         end
         S_ERR2:  resp = ERROR;
         default: ;
      endcase
   end

   assign HResp = resp;

   // Address-phase capture and wait-state countdown
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= addr_idx;
            write_q <= HWrite && !dec_err;
         end
         if (accept && !dec_err) begin
            wait_cnt <= WS_LOAD;
         end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
      end
   end

   ahb_sram_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (addr_q),
      .wdata (HWData),
      .re    (mem_re),
      .raddr (mem_raddr),
      .rdata (HRData)
   );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;
   localparam logic [1:0] R_OK     = 2'b00;
   localparam logic [1:0] R_ERR    = 2'b01;
   localparam logic [31:0] B2      = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel, hwrite, stall, use_ws0;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [31:0] rdata0, rdata2, rdata;
   logic        rdy0, rdy2, rdy;
   logic [1:0]  resp0, resp2, resp;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          burst_cycles;

   always #5 clk = ~clk;

   assign rdata = use_ws0 ? rdata0 : rdata2;
   assign rdy   = use_ws0 ? rdy0   : rdy2;
   assign resp  = use_ws0 ? resp0  : resp2;

   ahb_sram_slave #(.DEPTH(256), .BASE_ADDR(B2), .WAIT_STATES(2)) u_dut_ws2 (
      .clk(clk), .rst(rst), .HSel(hsel & ~use_ws0), .HAddr(haddr), .HTrans(htrans),
      .HWrite(hwrite), .ReadyIn(rdy2 & ~stall), .HWData(hwdata),
      .HRData(rdata2), .HReadyOut(rdy2), .HResp(resp2));

   ahb_sram_slave #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_ws0 (
      .clk(clk), .rst(rst), .HSel(hsel & use_ws0), .HAddr(haddr), .HTrans(htrans),
      .HWrite(hwrite), .ReadyIn(rdy0 & ~stall), .HWData(hwdata),
      .HRData(rdata0), .HReadyOut(rdy0), .HResp(resp0));

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic [1:0] tr, input logic wr, input logic [31:0] a);
      hsel   = 1'b1;
      htrans = tr;
      hwrite = wr;
      haddr  = a;
   endtask

   task automatic data_phase(input string tag, input logic chk_rd, input logic [31:0] wd,
                             input int exp_waits, input logic [1:0] exp_resp,
                             input logic [31:0] exp_rd);
      int         waits = 0;
      logic [1:0] first_resp = 2'bxx;
      htrans = T_IDLE;
      hwdata = wd;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 0) first_resp = resp;
         if (rdy) break;
         waits++;
      end
      chk_eq({tag, " waits"}, 32'(waits), 32'(exp_waits));
      chk_eq({tag, " first resp"}, 32'(first_resp), 32'(exp_resp));
      chk_eq({tag, " last resp"}, 32'(resp), 32'(exp_resp));
      if (chk_rd) chk_eq({tag, " rdata"}, rdata, exp_rd);
      tick();
   endtask

   task automatic xfer(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_waits,
                       input logic [1:0] exp_resp, input logic chk_rd,
                       input logic [31:0] exp_rd);
      addr_phase(T_NONSEQ, wr, a);
      tick();
      data_phase(tag, chk_rd, wd, exp_waits, exp_resp, exp_rd);
   endtask

   task automatic burst(input logic [31:0] a0, output int cycles);
      int   a_idx = 0;
      int   d_idx = -1;
      logic r;
      cycles = 0;
      addr_phase(T_NONSEQ, 1'b1, a0);
      for (int it = 0; it < 64; it++) begin
         @(negedge clk);
         r = rdy;
         if (d_idx >= 0) cycles++;
         tick();
         if (r) begin
            d_idx = (a_idx < 4) ? a_idx : -1;
            if (d_idx >= 0) hwdata = 32'(32'h11 * (d_idx + 1));
            a_idx++;
            if (a_idx < 4) addr_phase(T_SEQ, 1'b1, a0 + 32'(4 * a_idx));
            else htrans = T_IDLE;
            if (d_idx < 0) break;
         end
      end
   endtask

   initial begin
      rst = 1'b0; hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
      haddr = '0; hwdata = '0; stall = 1'b0; use_ws0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("reset ws2 ready", 32'(rdy2), 32'd1);
      chk_eq("reset ws2 resp", 32'(resp2), 32'd0);
      chk_eq("reset ws2 rdata", rdata2, 32'h0);
      chk_eq("reset ws0 ready", 32'(rdy0), 32'd1);
      rst = 1'b1;
      tick();

      // Wait-state write then read
      xfer("ws2 wr 0x10", 1'b1, B2 + 32'h10, 32'hDEAD_BEEF, 2, R_OK, 1'b0, '0);
      xfer("ws2 rd 0x10", 1'b0, B2 + 32'h10, '0, 2, R_OK, 1'b1, 32'hDEAD_BEEF);

      // IDLE and BUSY: zero-wait OKAY, no write
      addr_phase(T_IDLE, 1'b1, B2 + 32'h10);
      hwdata = 32'hFFFF_0000;
      @(negedge clk);
      chk_eq("idle ready", 32'(rdy), 32'd1);
      chk_eq("idle resp", 32'(resp), 32'd0);
      tick();
      addr_phase(T_BUSY, 1'b1, B2 + 32'h10);
      @(negedge clk);
      chk_eq("busy ready", 32'(rdy), 32'd1);
      chk_eq("busy resp", 32'(resp), 32'd0);
      tick();
      tick();
      xfer("rd after idle/busy", 1'b0, B2 + 32'h10, '0, 2, R_OK, 1'b1, 32'hDEAD_BEEF);

      // Errors: outside window, misaligned, below base; HRData holds
      xfer("ws2 wr word0", 1'b1, B2, 32'hA0A0_A0A0, 2, R_OK, 1'b0, '0);
      xfer("ws2 wr word255", 1'b1, B2 + 32'h3FC, 32'h5555_AAAA, 2, R_OK, 1'b0, '0);
      xfer("err wr top", 1'b1, B2 + 32'h400, 32'hBAD0_BAD0, 1, R_ERR, 1'b0, '0);
      xfer("err rd misaligned", 1'b0, B2 + 32'h2, '0, 1, R_ERR, 1'b1, 32'hDEAD_BEEF);
      xfer("err rd below base", 1'b0, B2 - 32'h4, '0, 1, R_ERR, 1'b1, 32'hDEAD_BEEF);
      xfer("rd word0", 1'b0, B2, '0, 2, R_OK, 1'b1, 32'hA0A0_A0A0);
      xfer("rd word255", 1'b0, B2 + 32'h3FC, '0, 2, R_OK, 1'b1, 32'h5555_AAAA);

      // Stalled bus: no accept until ReadyIn returns
      stall = 1'b1;
      addr_phase(T_NONSEQ, 1'b0, B2 + 32'h10);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk_eq("stall no accept", 32'(rdy), 32'd1);
         tick();
      end
      stall = 1'b0;
      tick();
      data_phase("rd after stall", 1'b1, '0, 2, R_OK, 32'hDEAD_BEEF);

      // Reset in the middle of a wait-stated write
      xfer("ws2 wr 0x20", 1'b1, B2 + 32'h20, 32'h1111_2222, 2, R_OK, 1'b0, '0);
      addr_phase(T_NONSEQ, 1'b1, B2 + 32'h20);
      tick();
      htrans = T_IDLE;
      hwdata = 32'h7777_7777;
      #2;
      rst = 1'b0;
      #1;
      chk_eq("mid-wait rst ready", 32'(rdy), 32'd1);
      chk_eq("mid-wait rst resp", 32'(resp), 32'd0);
      chk_eq("mid-wait rst rdata", rdata, 32'h0);
      tick();
      rst = 1'b1;
      tick();
      xfer("rd 0x20 after rst", 1'b0, B2 + 32'h20, '0, 2, R_OK, 1'b1, 32'h1111_2222);

      // Four-beat SEQ burst
      burst(B2 + 32'h40, burst_cycles);
      chk_eq("burst cycles", 32'(burst_cycles), 32'd12);
      for (int i = 0; i < 4; i++) begin
         xfer("burst word", 1'b0, B2 + 32'h40 + 32'(4 * i), '0, 2, R_OK, 1'b1, 32'(32'h11 * (i + 1)));
      end

      // Zero-wait instance: back-to-back write then read of word 3
      use_ws0 = 1'b1;
      tick();
      addr_phase(T_NONSEQ, 1'b1, 32'hC);
      tick();
      addr_phase(T_NONSEQ, 1'b0, 32'hC);
      hwdata = 32'h1234_5678;
      @(negedge clk);
      chk_eq("fwd write ready", 32'(rdy), 32'd1);
      tick();
      htrans = T_IDLE;
      @(negedge clk);
      chk_eq("fwd read ready", 32'(rdy), 32'd1);
      chk_eq("fwd read resp", 32'(resp), 32'd0);
      chk_eq("fwd read rdata", rdata, 32'h1234_5678);
      tick();
      xfer("ws0 rd word3", 1'b0, 32'hC, '0, 0, R_OK, 1'b1, 32'h1234_5678);
      xfer("ws0 err rd", 1'b0, 32'h2, '0, 1, R_ERR, 1'b1, 32'h1234_5678);
      xfer("ws0 wr word0", 1'b1, 32'h0, 32'hCAFE_0000, 0, R_OK, 1'b0, '0);
      xfer("ws0 err wr top", 1'b1, 32'h400, 32'hBAD0_BAD0, 1, R_ERR, 1'b0, '0);
      xfer("ws0 rd word0", 1'b0, 32'h0, '0, 0, R_OK, 1'b1, 32'hCAFE_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
